rtx_timeout_scanner: RTL and testbench

//  Per-flow retransmit-timer table feeding user_defined_timeout. Timers are armed/disarmed by the
//  ack/tx path; a round-robin scanner compares each armed deadline with `now`. An expired flow is

---
 rtl/rtx_timeout_scanner.sv | 135 +++++++++++++
 tb/tb_rtx_timeout_scanner.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtx_timeout_scanner.sv
// Per-flow retransmit timer table with a round-robin expiry scanner and a valid/ready event output.
// Optional macro RTX_TIMEOUT_STATS_EN enables the accepted-event counter on to_cnt.
`ifndef TIME_W
`define TIME_W 16
`endif
`ifndef TIMER_W
`define TIMER_W 12
`endif

module rtx_timeout_scanner #(
  parameter int FLOW_CNT  = 16,
  parameter int FLOW_ID_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [`TIME_W-1:0]   now,
  input  logic                 scan_en,
  input  logic                 arm_valid,
  input  logic [FLOW_ID_W-1:0] arm_flow_id,
  input  logic [`TIMER_W-1:0]  arm_amnt,
  input  logic                 disarm_valid,
  input  logic [FLOW_ID_W-1:0] disarm_flow_id,
  output logic                 to_valid,
  input  logic                 to_ready,
  output logic [FLOW_ID_W-1:0] to_flow_id,
  output logic [`TIME_W-1:0]   to_time,
  output logic [31:0]          to_cnt
);

  localparam int TIME_W = `TIME_W;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_reg;
  logic [FLOW_ID_W-1:0] ptr_reg;

  logic [FLOW_CNT-1:0]  active_vec;
  logic [FLOW_CNT-1:0]  arm_hit;
  logic [FLOW_CNT-1:0]  disarm_hit;
  logic [FLOW_CNT-1:0]  capture_hit;
  logic [TIME_W-1:0]    deadline_vec [FLOW_CNT];

  logic [TIME_W-1:0]    arm_deadline;
  logic [TIME_W-1:0]    scan_diff;
  logic                 scan_expired;
  logic                 scan_collide;
  logic                 capture;

  assign arm_deadline = now + TIME_W'(arm_amnt);

  // Wrap-safe compare: expired while now sits in the half-range at/after the deadline.
  assign scan_diff    = now - deadline_vec[ptr_reg];
  assign scan_expired = active_vec[ptr_reg] & ~scan_diff[TIME_W-1];
  assign scan_collide = arm_hit[ptr_reg] | disarm_hit[ptr_reg];
  assign capture      = (state_reg == SCAN) && scan_en && scan_expired && !scan_collide;

  generate
    for (genvar gi = 0; gi < FLOW_CNT; gi++) begin : g_flow
      logic              active_reg;
      logic [TIME_W-1:0] deadline_reg;

      assign arm_hit[gi]     = arm_valid && (arm_flow_id == FLOW_ID_W'(gi));
      assign disarm_hit[gi]  = disarm_valid && (disarm_flow_id == FLOW_ID_W'(gi));
      assign capture_hit[gi] = capture && (ptr_reg == FLOW_ID_W'(gi));

      // Arm takes priority over a same-cycle disarm; capture never coincides with either.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          active_reg   <= 1'b0;
          deadline_reg <= '0;
        end else if (arm_hit[gi]) begin
          active_reg   <= 1'b1;
          deadline_reg <= arm_deadline;
        end else if (disarm_hit[gi] || capture_hit[gi]) begin
          active_reg   <= 1'b0;
        end
      end

      assign active_vec[gi]   = active_reg;
      assign deadline_vec[gi] = deadline_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= SCAN;
      ptr_reg    <= '0;
      to_valid   <= 1'b0;
      to_flow_id <= '0;
      to_time    <= '0;
    end else begin
      case (state_reg)
        SCAN: begin
          if (scan_en) begin
            ptr_reg <= ptr_reg + FLOW_ID_W'(1);
            if (capture) begin
              to_flow_id <= ptr_reg;
              to_time    <= now;
              to_valid   <= 1'b1;
              state_reg  <= HOLD;
            end
          end
        end
        HOLD: begin
          // Event stays up until accepted, even if its flow is re-armed meanwhile.
          if (to_ready) begin
            to_valid  <= 1'b0;
            state_reg <= SCAN;
          end
        end
        default: state_reg <= SCAN;
      endcase
    end
  end

`ifdef RTX_TIMEOUT_STATS_EN
  logic [31:0] to_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_reg <= 32'd0;
    end else if (to_valid && to_ready) begin
      to_cnt_reg <= to_cnt_reg + 32'd1;
    end
  end

  assign to_cnt = to_cnt_reg;
`else
  assign to_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rtx_timeout_scanner.sv
// Testbench for rtx_timeout_scanner: vector table, directed corner sequences and a random
// run checked by a flow-table scoreboard.
`ifndef TIME_W
`define TIME_W 16
`endif
`ifndef TIMER_W
`define TIMER_W 12
`endif

module tb_rtx_timeout_scanner;

  localparam int FC  = 16;
  localparam int IDW = 4;
  localparam int TW  = `TIME_W;
  localparam int AW  = `TIMER_W;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [TW-1:0]  now = '0;
  logic           scan_en = 1'b1;
  logic           arm_valid = 1'b0;
  logic [IDW-1:0] arm_flow_id = '0;
  logic [AW-1:0]  arm_amnt = '0;
  logic           disarm_valid = 1'b0;
  logic [IDW-1:0] disarm_flow_id = '0;
  logic           to_valid;
  logic           to_ready = 1'b1;
  logic [IDW-1:0] to_flow_id;
  logic [TW-1:0]  to_time;
  logic [31:0]    to_cnt;

  rtx_timeout_scanner #(.FLOW_CNT(FC), .FLOW_ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .now(now), .scan_en(scan_en),
    .arm_valid(arm_valid), .arm_flow_id(arm_flow_id), .arm_amnt(arm_amnt),
    .disarm_valid(disarm_valid), .disarm_flow_id(disarm_flow_id),
    .to_valid(to_valid), .to_ready(to_ready), .to_flow_id(to_flow_id),
    .to_time(to_time), .to_cnt(to_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference flow table: which flows hold a running timer and their absolute deadlines.
  bit            m_active   [FC];
  logic [TW-1:0] m_deadline [FC];
  int            events;
  int            accepts;
  int            ev_flow [FC];

  typedef struct {
    int start;
    int flow;
    int amnt;
    int exp_flow;
    int exp_lo;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int f = 0; f < FC; f++) begin
      m_active[f]   = 1'b0;
      m_deadline[f] = '0;
      ev_flow[f]    = 0;
    end
    events  = 0;
    accepts = 0;
  endtask

  // One clock: remember what the DUT sees at the edge, then check the outcome against the table.
  task automatic step();
    bit             e_arm, e_dis, e_scan, e_ready, e_rst, p_valid;
    logic [IDW-1:0] e_arm_id, e_dis_id, p_flow, f;
    logic [AW-1:0]  e_amnt;
    logic [TW-1:0]  e_now, p_time, diff;
    e_arm = arm_valid; e_arm_id = arm_flow_id; e_amnt = arm_amnt;
    e_dis = disarm_valid; e_dis_id = disarm_flow_id;
    e_scan = scan_en; e_ready = to_ready; e_now = now; e_rst = rst;
    p_valid = to_valid; p_flow = to_flow_id; p_time = to_time;
    @(posedge clk);
    #1;
    if (!e_rst) begin
      if (p_valid) begin
        if (e_ready) begin
          accepts++;
          chk(to_valid == 1'b0, "accept_clears_valid", to_valid, 0);
        end else begin
          chk(to_valid == 1'b1, "hold_valid", to_valid, 1);
          chk(to_flow_id == p_flow, "hold_flow", to_flow_id, p_flow);
          chk(to_time == p_time, "hold_time", to_time, p_time);
        end
      end else if (to_valid) begin
        f = to_flow_id;
        events++;
        ev_flow[f]++;
        $display("event flow=%0d time=%0d", f, to_time);
        chk(m_active[f], "event_flow_active", 0, 1);
        chk(!(e_arm && e_arm_id == f) && !(e_dis && e_dis_id == f), "event_no_collision", f, -1);
        chk(e_scan, "event_scan_en", e_scan, 1);
        chk(to_time == e_now, "event_time", to_time, e_now);
        diff = to_time - m_deadline[f];
        chk(!diff[TW-1], "event_expired", to_time, m_deadline[f]);
        m_active[f] = 1'b0;
      end
      if (e_dis) m_active[e_dis_id] = 1'b0;
      if (e_arm) begin
        m_active[e_arm_id]   = 1'b1;
        m_deadline[e_arm_id] = e_now + TW'(e_amnt);
      end
    end
    now = now + 1'b1;
  endtask

  task automatic do_reset(input string nm);
    arm_valid = 1'b0;
    disarm_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk(to_valid == 1'b0, {nm, "_rst_valid"}, to_valid, 0);
    chk(to_flow_id == '0, {nm, "_rst_flow"}, to_flow_id, 0);
    chk(to_time == '0, {nm, "_rst_time"}, to_time, 0);
    chk(to_cnt == 32'd0, {nm, "_rst_cnt"}, to_cnt, 0);
    step();
    step();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic arm(input int flow, input int amnt);
    arm_valid = 1'b1;
    arm_flow_id = IDW'(flow);
    arm_amnt = AW'(amnt);
  endtask

  task automatic wait_valid(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i <= max_cyc && !got; i++) begin
      if (to_valid) got = 1'b1;
      else step();
    end
  endtask

  initial begin
    bit got;
    int d;
    int exp_cnt;

    vecs[0] = '{start: 100,   flow: 3,  amnt: 20,   exp_flow: 3,  exp_lo: 120};
    vecs[1] = '{start: 65530, flow: 5,  amnt: 10,   exp_flow: 5,  exp_lo: 4};
    vecs[2] = '{start: 200,   flow: 0,  amnt: 0,    exp_flow: 0,  exp_lo: 200};
    vecs[3] = '{start: 1000,  flow: 15, amnt: 4095, exp_flow: 15, exp_lo: 5095};
    vecs[4] = '{start: 500,   flow: 9,  amnt: 1,    exp_flow: 9,  exp_lo: 501};

    #2;
    model_clear();

    // Single-flow expiry vectors, including a deadline that wraps past 2^TIME_W.
    for (int v = 0; v < 5; v++) begin
      scan_en = 1'b1;
      to_ready = 1'b1;
      do_reset("vec");
      now = TW'(vecs[v].start);
      arm(vecs[v].flow, vecs[v].amnt);
      step();
      arm_valid = 1'b0;
      wait_valid(vecs[v].amnt + FC + 4, got);
      chk(got, "vec_event_seen", got, 1);
      chk(to_flow_id == IDW'(vecs[v].exp_flow), "vec_flow", to_flow_id, vecs[v].exp_flow);
      d = int'(TW'(to_time - TW'(vecs[v].exp_lo)));
      chk(d <= FC, "vec_time_window", to_time, vecs[v].exp_lo);
      repeat (200) step();
      chk(events == 1, "vec_single_event", events, 1);
    end

    // Reset asserted while an event is held.
    to_ready = 1'b0;
    do_reset("t1a");
    arm(2, 0);
    step();
    arm_valid = 1'b0;
    wait_valid(FC + 4, got);
    chk(got && to_flow_id == 2, "t1_held_event", to_flow_id, 2);
    do_reset("t1");
    to_ready = 1'b1;
    repeat (60) step();
    chk(events == 0, "t1_no_event_after_reset", events, 0);

    // Backpressure with two expired flows.
    to_ready = 1'b0;
    scan_en = 1'b0;
    do_reset("t4");
    arm(1, 0);
    step();
    arm(2, 0);
    step();
    arm_valid = 1'b0;
    scan_en = 1'b1;
    wait_valid(FC + 4, got);
    chk(got && to_flow_id == 1, "t4_first_flow", to_flow_id, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk(to_valid && to_flow_id == 1, "t4_held_stable", to_flow_id, 1);
    end
    to_ready = 1'b1;
    step();
    wait_valid(FC + 4, got);
    chk(got && to_flow_id == 2, "t4_second_flow", to_flow_id, 2);
    step();
    step();
`ifdef RTX_TIMEOUT_STATS_EN
    exp_cnt = 2;
`else
    exp_cnt = 0;
`endif
    chk(to_cnt == 32'(exp_cnt), "t4_to_cnt", to_cnt, exp_cnt);

    // Arm+disarm collision on flow 7, and an early disarm of flow 4.
    scan_en = 1'b0;
    do_reset("t5");
    arm(7, 50);
    disarm_valid = 1'b1;
    disarm_flow_id = 4'd7;
    step();
    disarm_valid = 1'b0;
    arm(4, 30);
    step();
    arm_valid = 1'b0;
    disarm_valid = 1'b1;
    disarm_flow_id = 4'd4;
    step();
    disarm_valid = 1'b0;
    scan_en = 1'b1;
    repeat (150) step();
    chk(ev_flow[7] == 1, "t5_flow7_event", ev_flow[7], 1);
    chk(ev_flow[4] == 0, "t5_flow4_no_event", ev_flow[4], 0);

    // Scanner paused with flow 0 expired.
    scan_en = 1'b0;
    do_reset("t6");
    arm(0, 0);
    step();
    arm_valid = 1'b0;
    repeat (30) step();
    chk(events == 0, "t6_paused_no_event", events, 0);
    scan_en = 1'b1;
    wait_valid(FC + 1, got);
    chk(got && to_flow_id == 0, "t6_event_after_enable", to_flow_id, 0);

    // Random traffic against the flow table.
    do_reset("rnd");
    for (int i = 0; i < 3000; i++) begin
      arm_valid = ($urandom_range(99) < 10);
      arm_flow_id = IDW'($urandom_range(FC - 1));
      arm_amnt = AW'($urandom_range(300));
      disarm_valid = ($urandom_range(99) < 5);
      disarm_flow_id = IDW'($urandom_range(FC - 1));
      scan_en = ($urandom_range(99) < 90);
      to_ready = ($urandom_range(99) < 60);
      step();
    end
    arm_valid = 1'b0;
    disarm_valid = 1'b0;
    scan_en = 1'b1;
    to_ready = 1'b1;
    repeat (400) step();
    chk(events > 0, "rnd_events_seen", events, 1);
    for (int f = 0; f < FC; f++) begin
      chk(!m_active[f], "rnd_drained", f, -1);
    end
    chk(accepts == events, "rnd_accepts", accepts, events);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
